seg7_display_sched: RTL and testbench
=====================================

# seg7_display_sched

Scheduler that shares the 8-digit 7-segment display path between several status sources: vector count, miscompare count, error code and so on. It round-robin grants one requester at a time and snapshots that requester's 32-bit value. It then sequences the display driver's `load` / `NUM` / `rd` controls: load phase (conversion plus spinner animation), then show phase (decoded digits) for a fixed dwell. It sits between the status producers and the 7-segment driver, in the driver's slow user clock domain.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `LOAD_CYC`, 64: clk cycles `load` is held per grant (≥2; covers ASCII conversion).
- `DWELL`, 1024: clk cycles `rd` is held per grant (≥1).

Ports:
- `clk` in 1: user clock; all logic on posedge.
- `reset` in 1: asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `req` in NREQ: level request per source.
- `num_bus` in 32*NREQ: source i value at bits [32*i+31:32*i].
- `grant` out NREQ: one-hot owner; 0 when idle.
- `src_id` out clog2(NREQ): index of owner; holds last owner when idle.
- `load` out 1: to display driver `load`.
- `rd` out 1: to display driver `rd`.
- `NUM` out 32: snapshot value to display driver.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, LOAD, SHOW.
- Arbitration is evaluated only in IDLE, and on the last SHOW cycle.
- Round-robin: search starts at `(last_owner+1) mod NREQ`; first set `req` bit wins; after reset `last_owner = NREQ-1`, so source 0 has first priority.
- On a win: `grant` and `src_id` are set, `NUM` captures `num_bus` slice of the winner, and the state goes to LOAD.
- LOAD: `load=1`, `rd=0` for exactly LOAD_CYC cycles, then SHOW.
- SHOW: `load=0`, `rd=1` for exactly DWELL cycles.
  - On the last cycle, arbitrate: a winner goes to LOAD with a fresh snapshot, including re-grant of the same source if it is the only requester.
  - No request goes to IDLE.
- IDLE: `load=rd=0`, `grant=0`; `NUM` holds the last snapshot, so the display keeps its last digits.
- `NUM` never changes outside a grant edge. Source value changes after capture are ignored until the next grant.
- Deassertion of `req` by the owner mid-grant does not shorten the grant; phases run to completion.
- `load` and `rd` are never high together. There is no cycle with both low between SHOW and the next LOAD.
- Phase counter: single down-counter, width clog2(max(LOAD_CYC, DWELL))+1, loaded on each phase entry; saturates at 0.
- Reset, at any time including mid-phase: immediate IDLE, counter 0, pointer reset.

## Timing
- Reset values: `grant=0`, `src_id=0`, `load=0`, `rd=0`, `NUM=0`, `busy=0`.
- `req` seen high in IDLE at edge k: `load`, `grant`, `NUM`, `busy` valid after edge k (registered outputs, 1-cycle latency).
- `load` high for cycles k+1 .. k+LOAD_CYC.
- `rd` high for cycles k+LOAD_CYC+1 .. k+LOAD_CYC+DWELL.
- Back-to-back grant: next `load` rises in the cycle immediately after the last `rd` cycle.
- Grant period is exactly LOAD_CYC+DWELL cycles.
- All outputs are registered; no combinational path from `req` / `num_bus` to outputs.

## Structure
- Shared package `seg7_pkg`:
  - state enum (IDLE/LOAD/SHOW);
  - `NUM_W=32`;
  - default LOAD_CYC/DWELL constants.
- Sub-module `rr_arbiter`: combinational next-owner from `req` and `last_owner`, plus a valid flag. The FSM, counter and snapshot registers live in the top level.

## Test plan
Bench uses NREQ=4, LOAD_CYC=4, DWELL=8.
- Reset released, `req=0` for 50 cycles -> all outputs 0, `busy=0`.
- `req=0001`, slice0=32'd12345 at edge k -> `load` cycles k+1..k+4, `rd` k+5..k+12, `NUM=12345`, `grant=0001`; `req` held, so re-grant of src 0 with `load` at k+13.
- `req=1111` continuously -> grant order 0,1,2,3,0; each period 12 cycles; `NUM` matches each slice value at its grant edge.
- Owner drops `req` 2 cycles into LOAD; `req=0100` raised during SHOW -> grant still completes the full 12 cycles, then src 2 granted with no gap.
- Slice1 changed from 7 to 9 during SHOW of src 1 -> `NUM` stays 7 until next grant; then 9.
- `reset` pulsed mid-SHOW, asynchronous and between clock edges -> outputs 0 immediately. After release with `req=1000`, src 0's priority pointer is reset and src 3 is granted.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment display scheduler.
// Holds the phase state enum and default phase lengths.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHOW
  } state_t;

  localparam int NUM_W        = 32;
  localparam int LOAD_CYC_DEF = 64;
  localparam int DWELL_DEF    = 1024;

endpackage

// File: rtl/seg7_display_sched_rr_arbiter.sv
// Round-robin next-owner picker, purely combinational.
// Search starts one past last_owner and wraps; nearest set req wins.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_owner,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  // Walk from farthest to nearest so the nearest requester overrides.
  always_comb begin
    valid  = 1'b0;
    winner = last_owner;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last_owner) + k) % NREQ]) begin
        valid  = 1'b1;
        winner = IW'((int'(last_owner) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/seg7_display_sched.sv
// Shares the 7-segment display driver between several status sources.
// Grants one source, snapshots its value, runs load then show phases.
module seg7_display_sched
  import seg7_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int LOAD_CYC = LOAD_CYC_DEF,
  parameter  int DWELL    = DWELL_DEF,
  localparam int IW       = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NUM_W*NREQ-1:0] num_bus,
  output logic [NREQ-1:0]       grant,
  output logic [IW-1:0]         src_id,
  output logic                  load,
  output logic                  rd,
  output logic [NUM_W-1:0]      NUM,
  output logic                  busy
);

  localparam int MAXC = (LOAD_CYC > DWELL) ? LOAD_CYC : DWELL;
  localparam int CW   = $clog2(MAXC) + 1;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] ptr;
  logic [IW-1:0] winner;
  logic          valid;
  logic          take;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req       (req),
    .last_owner(ptr),
    .winner    (winner),
    .valid     (valid)
  );

  // Phase sequencing; arbitration only when idle or on the last show cycle.
  always_comb begin
    state_n = state;
    cnt_n   = (cnt != '0) ? cnt - 1'b1 : '0;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (valid) take = 1'b1;
      end
      LOAD: begin
        if (cnt == '0) begin
          state_n = SHOW;
          cnt_n   = CW'(DWELL - 1);
        end
      end
      SHOW: begin
        if (cnt == '0) begin
          if (valid) begin
            take = 1'b1;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    if (take) begin
      state_n = LOAD;
      cnt_n   = CW'(LOAD_CYC - 1);
    end
  end

  // State, counter, pointer and snapshot registers; snapshot only on a grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      ptr    <= IW'(NREQ - 1);
      grant  <= '0;
      src_id <= '0;
      NUM    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (take) begin
        ptr    <= winner;
        src_id <= winner;
        grant  <= NREQ'(1) << winner;
        NUM    <= num_bus[int'(winner)*NUM_W +: NUM_W];
      end else if (state_n == IDLE) begin
        grant <= '0;
      end
    end
  end

  assign load = (state == LOAD);
  assign rd   = (state == SHOW);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_seg7_display_sched.sv
// Self-checking bench for seg7_display_sched.
// Table vectors, directed corner sequences and a random run vs a timeline model.
module tb_seg7_display_sched;

  localparam int N   = 4;
  localparam int LC  = 4;
  localparam int DW  = 8;
  localparam int PER = LC + DW;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [32*N-1:0] num_bus;
  logic [N-1:0]    grant;
  logic [1:0]      src_id;
  logic            load;
  logic            rd;
  logic [31:0]     NUM;
  logic            busy;

  int total = 0;
  int bad   = 0;

  bit          m_busy;
  int          m_t;
  int          m_own;
  int          m_ptr;
  int          m_src;
  logic [31:0] m_num;

  typedef struct {
    logic [3:0]  req;
    logic        ld;
    logic        rd;
    logic [3:0]  g;
    logic [31:0] num;
  } vec_t;

  vec_t tbl[13];

  seg7_display_sched #(
    .NREQ    (N),
    .LOAD_CYC(LC),
    .DWELL   (DW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .num_bus(num_bus),
    .grant  (grant),
    .src_id (src_id),
    .load   (load),
    .rd     (rd),
    .NUM    (NUM),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_t    = 0;
    m_own  = 0;
    m_ptr  = N - 1;
    m_src  = 0;
    m_num  = '0;
  endtask

  // A grant lasts PER cycles; t counts cycles since the grant edge.
  task automatic model_step();
    bit won;
    won = 1'b0;
    if (m_busy && m_t < PER - 1) begin
      m_t++;
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (!won && req[(m_ptr + k) % N]) begin
          won   = 1'b1;
          m_own = (m_ptr + k) % N;
        end
      end
      if (won) begin
        m_busy = 1'b1;
        m_t    = 0;
        m_ptr  = m_own;
        m_src  = m_own;
        m_num  = num_bus[32*m_own +: 32];
      end else begin
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic chk_model();
    logic [3:0] eg;
    logic       el;
    logic       er;
    eg = m_busy ? (4'b0001 << m_own) : 4'b0000;
    el = m_busy && (m_t < LC);
    er = m_busy && (m_t >= LC);
    chk("model", {grant, src_id, load, rd, busy, NUM},
        {eg, 2'(m_src), el, er, m_busy, m_num});
    chk("excl", {63'd0, load & rd}, 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_slice(int i, logic [31:0] v);
    num_bus[32*i +: 32] = v;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 13; i++) begin
      tbl[i].req = 4'b0001;
      tbl[i].ld  = (i < LC) || (i == PER);
      tbl[i].rd  = (i >= LC) && (i < PER);
      tbl[i].g   = 4'b0001;
      tbl[i].num = 32'd12345;
    end

    reset   = 1'b1;
    req     = '0;
    num_bus = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out", {grant, src_id, load, rd, busy, NUM}, 64'd0);
    reset = 1'b0;

    repeat (50) tick();
    chk("idle50", {grant, src_id, load, rd, busy, NUM}, 64'd0);

    do_reset();
    set_slice(0, 32'd12345);
    for (int i = 0; i < 13; i++) begin
      req = tbl[i].req;
      tick();
      chk($sformatf("tbl%0d", i), {load, rd, grant, NUM},
          {tbl[i].ld, tbl[i].rd, tbl[i].g, tbl[i].num});
    end

    do_reset();
    for (int i = 0; i < N; i++) set_slice(i, 32'd100 + 32'(i));
    req = 4'b1111;
    tick();
    chk("rr0", {src_id, NUM, grant, load}, {2'd0, 32'd100, 4'b0001, 1'b1});
    for (int g = 1; g <= 4; g++) begin
      repeat (PER) tick();
      chk($sformatf("rr%0d", g), {src_id, NUM, grant, load},
          {2'(g % 4), 32'd100 + 32'(g % 4), 4'b0001 << (g % 4), 1'b1});
    end

    do_reset();
    req = 4'b0001;
    tick();
    repeat (2) tick();
    req = 4'b0000;
    repeat (3) tick();
    req = 4'b0100;
    repeat (6) tick();
    chk("drop_full", {rd, grant}, {1'b1, 4'b0001});
    tick();
    chk("drop_next", {src_id, load, grant}, {2'd2, 1'b1, 4'b0100});

    do_reset();
    set_slice(1, 32'd7);
    req = 4'b0010;
    tick();
    repeat (LC) tick();
    set_slice(1, 32'd9);
    chk("snap_hold", {rd, NUM}, {1'b1, 32'd7});
    repeat (DW - 1) tick();
    chk("snap_last", {rd, NUM}, {1'b1, 32'd7});
    tick();
    chk("snap_new", {load, NUM}, {1'b1, 32'd9});

    do_reset();
    req = 4'b0001;
    tick();
    repeat (LC + 2) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("arst1", {grant, src_id, load, rd, busy, NUM}, 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b1001;
    tick();
    chk("ptr_rst", {src_id, grant}, {2'd0, 4'b0001});
    repeat (LC + 3) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("arst2", {grant, src_id, load, rd, busy, NUM}, 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b1000;
    tick();
    chk("src3", {src_id, grant, load}, {2'd3, 4'b1000, 1'b1});

    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) req = '0;
      if ($urandom_range(0, 1) == 0)
        set_slice($urandom_range(0, N - 1), $urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
